// File: rtl/alu_datapath.sv
// alu_datapath: 8-bit ALU datapath steered by a one-hot control word.
// Supports add/sub, Booth radix-2 signed multiply and non-restoring
// unsigned divide. Each control bit is one micro-operation. Status flags
// go back to the control unit, and results leave on outbus with a strobe.
module alu_datapath #(
  parameter int W = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [12:0]   c,
  input  logic [W-1:0]  inbus,
  output logic          q_0,
  output logic          q_min1,
  output logic          sign,
  output logic          cnt7,
  output logic [W-1:0]  outbus,
  output logic          out_valid
);

  localparam int CW = $clog2(W);

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_MUL = 2'd1;
  localparam logic [1:0] OP_DIV = 2'd2;

  logic [W:0]    a;
  logic [W-1:0]  q;
  logic          qm1;
  logic [W:0]    m;
  logic [CW-1:0] cnt;
  logic          s;
  logic [1:0]    op;

  logic          load_sel;
  logic          alu_sel;
  logic          step_sel;
  logic          out_sel;
  logic          cnt_last;
  logic [W:0]    addend;
  logic [W:0]    alu_sum;
  logic [W:0]    corr_sum;

  // Resolve illegal combinations: loads beat c4, c4 beats the step ops, and outputs come last.
  always_comb begin
    load_sel = |c[3:0];
    alu_sel  = ~load_sel & c[4];
    step_sel = ~load_sel & ~c[4] & (|c[10:6]);
    out_sel  = ~load_sel & ~c[4] & ~(|c[10:6]) & (|c[12:11]);
  end

  // The 9-bit adder: c5 turns it into A - M through two's complement of M.
  always_comb begin
    addend   = c[5] ? ~m : m;
    alu_sum  = a + addend + {{W{1'b0}}, c[5]};
    corr_sum = a + m;
    cnt_last = (cnt == CW'(W - 1));
  end

  // Datapath registers. Each control bit performs one micro-operation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a   <= '0;
      q   <= '0;
      qm1 <= 1'b0;
      m   <= '0;
      cnt <= '0;
      s   <= 1'b0;
      op  <= OP_ADD;
    end else if (load_sel) begin
      if (c[0]) begin
        a  <= {inbus[W-1], inbus};
        op <= OP_ADD;
        s  <= 1'b0;
      end else if (c[1]) begin
        a   <= '0;
        q   <= inbus;
        qm1 <= 1'b0;
        op  <= OP_MUL;
        s   <= 1'b0;
      end else if (c[2]) begin
        a  <= {{W{1'b0}}, inbus[W-1]};
        q  <= {inbus[W-2:0], 1'b0};
        op <= OP_DIV;
        s  <= 1'b0;
      end else begin
        cnt <= '0;
        m   <= (op == OP_DIV) ? {1'b0, inbus} : {inbus[W-1], inbus};
      end
    end else if (alu_sel) begin
      a <= alu_sum;
    end else if (step_sel) begin
      if (c[6]) begin
        q[0] <= ~a[W];
        s    <= a[W];
      end else if (c[7]) begin
        {a, q, qm1} <= {a[W], a, q};
      end else if (c[8]) begin
        if (cnt_last) begin
          cnt <= '0;
        end else begin
          {a, q} <= {a[W-1:0], q, 1'b0};
          cnt    <= cnt + 1'b1;
        end
      end else if (c[9]) begin
        cnt <= cnt + 1'b1;
      end else begin
        a <= corr_sum;
      end
    end
  end

  // Result port. c11 gives the primary result and c12 gives the high byte or remainder.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      outbus    <= '0;
      out_valid <= 1'b0;
    end else if (out_sel) begin
      out_valid <= 1'b1;
      if (c[11] && (op != OP_ADD)) begin
        outbus <= q;
      end else begin
        outbus <= a[W-1:0];
      end
    end else begin
      out_valid <= 1'b0;
    end
  end

  assign q_0    = q[0];
  assign q_min1 = qm1;
  assign sign   = s;
  assign cnt7   = cnt_last;

endmodule

// File: tb/tb_alu_datapath.sv
// tb_alu_datapath: acts as the control unit for alu_datapath. It runs
// the add/sub, Booth multiply and non-restoring divide sequences. A
// compare process checks every result cycle against expected bytes, which
// come from literals or from a plain-arithmetic model.
module tb_alu_datapath;

  localparam logic [12:0] C0  = 13'h0001;
  localparam logic [12:0] C1  = 13'h0002;
  localparam logic [12:0] C2  = 13'h0004;
  localparam logic [12:0] C3  = 13'h0008;
  localparam logic [12:0] C4  = 13'h0010;
  localparam logic [12:0] C5  = 13'h0020;
  localparam logic [12:0] C6  = 13'h0040;
  localparam logic [12:0] C7  = 13'h0080;
  localparam logic [12:0] C8  = 13'h0100;
  localparam logic [12:0] C9  = 13'h0200;
  localparam logic [12:0] C10 = 13'h0400;
  localparam logic [12:0] C11 = 13'h0800;
  localparam logic [12:0] C12 = 13'h1000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [12:0] c = '0;
  logic [7:0]  inbus = '0;
  logic        q_0;
  logic        q_min1;
  logic        sign;
  logic        cnt7;
  logic [7:0]  outbus;
  logic        out_valid;

  int errors = 0;
  int checks = 0;
  bit check_en = 1'b0;

  typedef struct packed {
    logic       valid;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t cmp_e;

  alu_datapath #(.W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .c         (c),
    .inbus     (inbus),
    .q_0       (q_0),
    .q_min1    (q_min1),
    .sign      (sign),
    .cnt7      (cnt7),
    .outbus    (outbus),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drive one control word for exactly one clock edge and record what the port must show after it.
  task automatic applyStimulus(input logic [12:0] cword, input logic [7:0] data, input logic [7:0] exp_data);
    exp_t e;
    c     = cword;
    inbus = data;
    e.valid = (cword[12:11] != 2'b00) && (cword[4:0] == 5'd0) && (cword[10:6] == 5'd0);
    e.data  = exp_data;
    if (check_en) exp_q.push_back(e);
    @(negedge clk);
  endtask

  // Compare process: after every edge, compare the output port with the next expected record.
  always @(posedge clk) begin
    #2;
    if (check_en && exp_q.size() > 0) begin
      cmp_e = exp_q.pop_front();
      checkOutput("out_valid", {15'd0, out_valid}, {15'd0, cmp_e.valid});
      if (cmp_e.valid) checkOutput("outbus", {8'd0, outbus}, {8'd0, cmp_e.data});
    end
  end

  function automatic logic [15:0] model_mul(input logic [7:0] x, input logic [7:0] y);
    int xs;
    int ys;
    int p;
    xs = $signed(x);
    ys = $signed(y);
    p  = xs * ys;
    return p[15:0];
  endfunction

  function automatic logic [15:0] model_div(input logic [7:0] x, input logic [7:0] y);
    int unsigned xq;
    int unsigned xr;
    if (y == 8'd0) return {8'hFF, x};
    xq = x / y;
    xr = x % y;
    return {xq[7:0], xr[7:0]};
  endfunction

  task automatic run_addsub(input logic [7:0] x, input logic [7:0] y, input bit sub, input logic [7:0] expected);
    applyStimulus(C0, x, 8'd0);
    applyStimulus(C3, y, 8'd0);
    applyStimulus(sub ? (C4 | C5) : C4, 8'd0, 8'd0);
    applyStimulus(C11, 8'd0, expected);
    applyStimulus('0, 8'd0, 8'd0);
  endtask

  task automatic mul_iteration(input int i);
    logic [12:0] cw;
    case ({q_0, q_min1})
      2'b10:   cw = C4 | C5;
      2'b01:   cw = C4;
      default: cw = '0;
    endcase
    applyStimulus(cw, 8'd0, 8'd0);
    applyStimulus(C7, 8'd0, 8'd0);
    checkOutput("cnt7_mul", {15'd0, cnt7}, (i == 7) ? 16'd1 : 16'd0);
    applyStimulus(C9, 8'd0, 8'd0);
  endtask

  task automatic run_mul(input logic [7:0] x, input logic [7:0] y, input logic [15:0] expected);
    applyStimulus(C1, x, 8'd0);
    applyStimulus(C3, y, 8'd0);
    for (int i = 0; i < 8; i++) mul_iteration(i);
    applyStimulus(C11, 8'd0, expected[7:0]);
    applyStimulus(C12, 8'd0, expected[15:8]);
    applyStimulus('0, 8'd0, 8'd0);
  endtask

  task automatic run_div(input logic [7:0] x, input logic [7:0] y, input logic [7:0] quo, input logic [7:0] rem);
    applyStimulus(C2, x, 8'd0);
    applyStimulus(C3, y, 8'd0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(C4 | (sign ? 13'd0 : C5), 8'd0, 8'd0);
      applyStimulus(C6, 8'd0, 8'd0);
      checkOutput("cnt7_div", {15'd0, cnt7}, (i == 7) ? 16'd1 : 16'd0);
      applyStimulus(C8, 8'd0, 8'd0);
    end
    if (sign) applyStimulus(C10, 8'd0, 8'd0);
    applyStimulus(C11, 8'd0, quo);
    applyStimulus(C12, 8'd0, rem);
    applyStimulus('0, 8'd0, 8'd0);
  endtask

  initial begin
    logic [7:0]  x;
    logic [7:0]  y;
    logic [15:0] r;
    int          kind;

    #1;
    checkOutput("reset_outbus", {8'd0, outbus}, 16'd0);
    checkOutput("reset_valid", {15'd0, out_valid}, 16'd0);
    checkOutput("reset_flags", {12'd0, q_0, q_min1, sign, cnt7}, 16'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    check_en = 1'b1;

    $display("[TB] directed vectors");
    run_addsub(8'h25, 8'h13, 1'b0, 8'h38);
    run_addsub(8'h10, 8'h20, 1'b1, 8'hF0);
    run_mul(8'hFD, 8'h05, 16'hFFF1);
    run_div(8'd100, 8'd7, 8'h0E, 8'h02);
    run_div(8'd200, 8'd0, 8'hFF, 8'hC8);
    run_mul(8'h80, 8'h80, 16'h4000);

    $display("[TB] reset during multiply");
    applyStimulus(C1, 8'hFD, 8'd0);
    applyStimulus(C3, 8'h05, 8'd0);
    for (int i = 0; i < 3; i++) mul_iteration(i);
    applyStimulus(C4 | C5, 8'd0, 8'd0);
    applyStimulus(C7, 8'd0, 8'd0);
    #1;
    check_en = 1'b0;
    rst = 1'b0;
    c = '0;
    #1;
    checkOutput("async_rst_outbus", {8'd0, outbus}, 16'd0);
    checkOutput("async_rst_valid", {15'd0, out_valid}, 16'd0);
    checkOutput("async_rst_flags", {12'd0, q_0, q_min1, sign, cnt7}, 16'd0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    check_en = 1'b1;
    run_addsub(8'h01, 8'h01, 1'b0, 8'h02);

    $display("[TB] load beats add in the same cycle");
    applyStimulus(C0 | C4, 8'h11, 8'd0);
    applyStimulus(C11, 8'd0, 8'h11);
    applyStimulus('0, 8'd0, 8'd0);

    $display("[TB] random vectors");
    repeat (24) begin
      x    = 8'($urandom);
      y    = 8'($urandom);
      kind = $urandom_range(0, 3);
      case (kind)
        0: run_addsub(x, y, 1'b0, x + y);
        1: run_addsub(x, y, 1'b1, x - y);
        2: run_mul(x, y, model_mul(x, y));
        default: begin
          r = model_div(x, y);
          run_div(x, y, r[15:8], r[7:0]);
        end
      endcase
    end

    applyStimulus('0, 8'd0, 8'd0);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_datapath.md
Name: alu_datapath

Overview:
- 8-bit ALU datapath driven by the one-hot control word `c[12:0]` from `control_unit`.
- Executes add/sub, Booth radix-2 signed multiply and non-restoring unsigned divide, one micro-operation per control bit.
- Returns the status flags `q_0`, `q_min1`, `sign` and `cnt7` to the control unit.
- Results leave on `outbus` with a valid strobe.

Parameters:
- W, 8, operand width. All text below assumes 8; A is W+1 bits, counter is log2(W) bits.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- c  input  13  one-hot control word (c[4] and c[5] may be set together)
- inbus  input  8  operand bus: X in c0/c1/c2 cycle, Y in c3 cycle
- q_0  output  1  Q[0]
- q_min1  output  1  Booth extension bit Q-1
- sign  output  1  registered sign flag S
- cnt7  output  1  combinational, counter == 7
- outbus  output  8  result data
- out_valid  output  1  outbus holds a result this cycle

Behaviour:
- Registers:
  - A[8:0], Q[7:0], Qm1, M[8:0]
  - CNT[2:0]
  - S
  - OP[1:0]: 0 add/sub, 1 mul, 2 div
  - outbus, out_valid
- Reset (rst=0, async): every register 0; all outputs 0.
- Priority when illegal combinations arrive: load bits (c0..c3) > c4 > c6..c10 > c11/c12. Lower-priority bits in the same cycle are ignored.
- Micro-operations (registered at clk edge):
  - c0: A <= sign-ext X; OP <= 0; S <= 0.
  - c1: A <= 0; Q <= X; Qm1 <= 0; OP <= 1; S <= 0.
  - c2: A <= {8'b0, X[7]}; Q <= {X[6:0], 0}; OP <= 2; S <= 0. This is the pre-shift for the first division step.
  - c3: CNT <= 0. M <= {Y[7], Y} for OP 0/1; M <= {1'b0, Y} for OP 2.
  - c4: A <= A + M when c5=0. A <= A + ~M + 1 when c5=1. All arithmetic is 9-bit and wraps.
  - c6 (div quotient bit): Q[0] <= ~A[8]; S <= A[8].
  - c7 (mul shift): arithmetic right shift of {A, Q, Qm1} by one; A[8] is replicated.
  - c8 (div step end):
    - If CNT != 7: {A, Q} <= {A[7:0], Q, 0} (left shift); CNT <= CNT + 1.
    - If CNT == 7: A and Q hold; CNT <= 0.
  - c9 (mul step end): CNT <= CNT + 1, wrapping 7 -> 0.
  - c10 (div remainder correction): A <= A + M.
  - c11: outbus <= A[7:0] if OP=0, else Q; out_valid <= 1.
  - c12: outbus <= A[7:0]; out_valid <= 1. This is the high product byte or the remainder.
  - No c11/c12 bit set: out_valid <= 0; outbus holds.
- Flag timing:
  - `cnt7` reflects CNT before that edge's increment, so the control unit sees 7 in the same cycle c8/c9 is asserted on the last iteration.
  - `q_0` and `q_min1` are valid one cycle after c1 and after each c7.
  - `sign` is S; S is not updated by c4.
- Results:
  - Multiply: signed 16-bit product {A[7:0], Q}, low byte out first.
  - Divide: quotient Q, then remainder A[7:0] after correction.
  - Add/sub: 8-bit wrapped result; the 9th bit is discarded.
- Divide by zero is not trapped: quotient 0xFF, remainder = X.
- Reset mid-operation aborts immediately, with no partial result on `outbus`.
- Latency equals the control unit's state count:
  - add: 4 cycles start-to-result
  - mul/div: 8 iterations of 3 cycles plus overhead; exact counts are set by the control unit.

Test Plan:
- Add/sub:
  - c0 with inbus=0x25, c3 with 0x13, c4, c11 -> outbus=0x38, out_valid one cycle.
  - Repeat with X=0x10, Y=0x20, c4|c5 -> outbus=0xF0.
- Multiply: X=0xFD (-3), Y=0x05, run the Booth sequence per q_0/q_min1 for 8 iterations -> cnt7 high on the 8th c9; c11 outbus=0xF1, then c12 outbus=0xFF.
- Divide: X=100, Y=7, non-restoring sequence driven by sign/cnt7 -> quotient 0x0E, remainder 0x02. Repeat with X=200, Y=0 -> quotient 0xFF, remainder 0xC8.
- Multiply edge: X=0x80, Y=0x80 -> product 0x4000 with no overflow in A, since A is 9 bits.
- Reset: pull rst low during the 4th multiply iteration -> all outputs 0 asynchronously, before the next edge. A following add (0x01+0x01) -> 0x02.
- Illegal combination: c0 and c4 together -> load only; A = sign-ext X and is not added to M.
